// File: rtl/ascon_msg_pad.sv
// Packs an Ascon message byte stream into 64-bit rate blocks, applies 0x80/zero
// padding and flags the final block for the hash controller.
module ascon_msg_pad #(
    parameter int RATE_BYTES = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [63:0]      blk_data,
    output logic             blk_last,
    output logic [CNT_W-1:0] msg_bytes
);

    typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

    localparam logic [3:0]  LAST_IDX  = 4'(RATE_BYTES - 1);
    localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [63:0]      r_buf;
    logic             r_last;
    logic             r_padPend;
    logic             r_blkValid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_handshake;
    logic [3:0]       w_idxAfter;
    logic [CNT_W-1:0] w_cntInc;
    logic [63:0]      w_nextBuf;

    assign in_ready    = (r_state == FILL) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_handshake = r_blkValid && blk_ready;
    assign w_idxAfter  = r_idx + 4'd1;
    assign w_cntInc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Buffer after the current beat: earlier bytes kept, this byte (or the pad
    // marker for an empty terminator) written, pad marker after a last data byte.
    always_comb begin
        w_nextBuf = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < r_idx) begin
                w_nextBuf[63-8*k -: 8] = r_buf[63-8*k -: 8];
            end else if (4'(k) == r_idx) begin
                w_nextBuf[63-8*k -: 8] = in_empty ? 8'h80 : in_data;
            end else if ((4'(k) == w_idxAfter) && in_last && !in_empty) begin
                w_nextBuf[63-8*k -: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_idx      <= '0;
            r_buf      <= '0;
            r_last     <= 1'b0;
            r_padPend  <= 1'b0;
            r_blkValid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (in_empty) begin
                            // An empty beat without in_last carries nothing and is dropped.
                            if (in_last) begin
                                r_buf      <= w_nextBuf;
                                r_last     <= 1'b1;
                                r_padPend  <= 1'b0;
                                r_blkValid <= 1'b1;
                                r_state    <= EMIT;
                            end
                        end else begin
                            r_buf <= w_nextBuf;
                            r_cnt <= w_cntInc;
                            if (r_idx == LAST_IDX) begin
                                r_idx      <= w_idxAfter;
                                r_last     <= 1'b0;
                                r_padPend  <= in_last;
                                r_blkValid <= 1'b1;
                                r_state    <= EMIT;
                            end else if (in_last) begin
                                r_last     <= 1'b1;
                                r_padPend  <= 1'b0;
                                r_blkValid <= 1'b1;
                                r_state    <= EMIT;
                            end else begin
                                r_idx <= w_idxAfter;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (w_handshake) begin
                        if (r_padPend) begin
                            r_buf     <= PAD_BLOCK;
                            r_last    <= 1'b1;
                            r_padPend <= 1'b0;
                            r_state   <= PAD;
                        end else begin
                            r_idx      <= '0;
                            r_buf      <= '0;
                            r_last     <= 1'b0;
                            r_blkValid <= 1'b0;
                            r_state    <= FILL;
                            if (r_last) begin
                                r_cnt <= '0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (w_handshake) begin
                        r_idx      <= '0;
                        r_buf      <= '0;
                        r_last     <= 1'b0;
                        r_blkValid <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign blk_valid = r_blkValid;
    assign blk_data  = r_buf;
    assign blk_last  = r_last;
    assign msg_bytes = r_cnt;

endmodule

// File: tb/tb_ascon_msg_pad.sv
// Self-checking bench for ascon_msg_pad: directed vectors plus randomized messages
// compared against a padded-message reference model.
module tb_ascon_msg_pad;

    localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    logic [63:0] blk_data;
    logic        blk_last;
    logic [31:0] msg_bytes;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       e;
    } beat_t;

    logic [7:0]  mBytes[$];
    beat_t       beats[$];
    logic [63:0] expData[$];
    logic        expLast[$];
    int          expLen;

    ascon_msg_pad dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .msg_bytes(msg_bytes)
    );

    always #5 clk = ~clk;

    // Expected blocks: message, then 0x80, then zeros up to a multiple of 8 bytes.
    task automatic buildModel(input bit emptyTerm, input int junkPct);
        logic [7:0] p[$];
        logic [63:0] blk;
        int n;
        int nBlk;
        beat_t bt;
        beats.delete();
        expData.delete();
        expLast.delete();
        n = mBytes.size();
        expLen = n;
        p = mBytes;
        p.push_back(8'h80);
        while (p.size() % 8 != 0) p.push_back(8'h00);
        nBlk = p.size() / 8;
        for (int b = 0; b < nBlk; b++) begin
            blk = '0;
            for (int j = 0; j < 8; j++) blk = {blk[55:0], p[8*b+j]};
            expData.push_back(blk);
            expLast.push_back(b == nBlk - 1);
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < junkPct) begin
                bt.d = 8'($urandom); bt.l = 1'b0; bt.e = 1'b1;
                beats.push_back(bt);
            end
            bt.d = mBytes[i]; bt.l = (i == n - 1) && !emptyTerm; bt.e = 1'b0;
            beats.push_back(bt);
        end
        if (emptyTerm || n == 0) begin
            bt.d = 8'($urandom); bt.l = 1'b1; bt.e = 1'b1;
            beats.push_back(bt);
        end
    endtask

    // Drives the prepared beats and consumes/checks blocks concurrently.
    task automatic runMsg(input int validPct, input int readyPct, input int holdCycles);
        fork
            begin : driver
                int i = 0;
                int cyc = 0;
                while (i < beats.size() && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    in_valid = ($urandom_range(99) < validPct);
                    in_data  = beats[i].d;
                    in_last  = beats[i].l;
                    in_empty = beats[i].e;
                    if (in_valid && in_ready) i++;
                end
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_empty = 1'b0;
                if (i < beats.size()) begin
                    total++; bad++;
                    $display("[TB] FAIL input_timeout accepted=%0d required=%0d", i, beats.size());
                end
            end
            begin : consumer
                int k = 0;
                int cyc = 0;
                int seen = 0;
                logic holding = 1'b0;
                logic [63:0] held = '0;
                logic heldLast = 1'b0;
                while (k < expData.size() && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    if (holding) begin
                        total++;
                        if (blk_valid !== 1'b1 || blk_data !== held || blk_last !== heldLast) begin
                            bad++;
                            $display("[TB] FAIL hold_stable valid=%b data=%h last=%b required data=%h last=%b",
                                     blk_valid, blk_data, blk_last, held, heldLast);
                        end
                    end
                    if (blk_valid) begin
                        total++;
                        if (in_ready !== 1'b0) begin
                            bad++;
                            $display("[TB] FAIL backpressure in_ready=%b required=0", in_ready);
                        end
                        seen++;
                        if (holdCycles > 0) blk_ready = (seen > holdCycles);
                        else blk_ready = ($urandom_range(99) < readyPct);
                        if (blk_ready) begin
                            total++;
                            if (blk_data !== expData[k] || blk_last !== expLast[k]) begin
                                bad++;
                                $display("[TB] FAIL block%0d data=%h last=%b required data=%h last=%b",
                                         k, blk_data, blk_last, expData[k], expLast[k]);
                            end
                            if (expLast[k]) begin
                                total++;
                                if (msg_bytes !== 32'(expLen)) begin
                                    bad++;
                                    $display("[TB] FAIL msg_bytes got=%0d required=%0d", msg_bytes, expLen);
                                end
                            end
                            k++;
                            seen = 0;
                            holding = 1'b0;
                        end else begin
                            holding = 1'b1;
                            held = blk_data;
                            heldLast = blk_last;
                        end
                    end else begin
                        blk_ready = 1'($urandom_range(1));
                    end
                end
                if (k < expData.size()) begin
                    total++; bad++;
                    $display("[TB] FAIL block_timeout got=%0d required=%0d", k, expData.size());
                end
                @(negedge clk);
                blk_ready = 1'b0;
                total++;
                if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL idle_after_msg valid=%b in_ready=%b required 0/1", blk_valid, in_ready);
                end
            end
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_data !== 64'h0 ||
            blk_last !== 1'b0 || msg_bytes !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_state rdy=%b v=%b d=%h l=%b n=%0d required all 0",
                     in_ready, blk_valid, blk_data, blk_last, msg_bytes);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset got=%b required=1", in_ready);
        end
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_last = 1'b1; in_empty = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        total++;
        if (blk_valid !== 1'b1 || blk_data !== PAD_BLOCK || blk_last !== 1'b1 || msg_bytes !== 32'h0) begin
            bad++;
            $display("[TB] FAIL latency_empty v=%b d=%h l=%b n=%0d required 1/%h/1/0",
                     blk_valid, blk_data, blk_last, msg_bytes, PAD_BLOCK);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        total++;
        if (blk_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latency_release v=%b required=0", blk_valid);
        end
    endtask

    task automatic test_spec_vectors();
        mBytes.delete();
        buildModel(1'b1, 0); runMsg(100, 100, 0);
        mBytes = '{8'h61, 8'h62, 8'h63};
        buildModel(1'b0, 0); runMsg(100, 100, 0);
        mBytes.delete();
        for (int i = 0; i < 8; i++) mBytes.push_back(8'(i));
        buildModel(1'b0, 0); runMsg(100, 100, 0);
        mBytes.delete();
        for (int i = 0; i < 10; i++) mBytes.push_back(8'(8'h10 + i));
        buildModel(1'b0, 0); runMsg(100, 100, 5);
        mBytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        buildModel(1'b1, 0); runMsg(100, 100, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(8'h20 + i); in_last = 1'b0; in_empty = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_data !== 64'h0 ||
            blk_last !== 1'b0 || msg_bytes !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid rdy=%b v=%b d=%h l=%b n=%0d required all 0",
                     in_ready, blk_valid, blk_data, blk_last, msg_bytes);
        end
        @(negedge clk);
        rst = 1'b0;
        mBytes = '{8'h41, 8'h42};
        buildModel(1'b0, 0); runMsg(100, 100, 0);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 4; m++) begin
            mBytes.delete();
            for (int i = 0; i < 3 + 4 * m; i++) mBytes.push_back(8'($urandom));
            buildModel(1'(m % 2), 0);
            runMsg(100, 100, 0);
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 40; m++) begin
            mBytes.delete();
            for (int i = 0; i < int'($urandom_range(20)); i++) mBytes.push_back(8'($urandom));
            buildModel(1'($urandom_range(1)), 15);
            runMsg(70, 60, 0);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_spec_vectors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
